// File: rtl/mire_pkg.sv
// mire_pkg: RGB565 colour constants, writer FSM state type and the bar
// colour lookup shared by the mire (test pattern) writer.
`timescale 1ns/1ps
package mire_pkg;

    localparam logic [15:0] GRID_GREY   = 16'h8410;
    localparam logic [15:0] BAR_WHITE   = 16'hFFFF;
    localparam logic [15:0] BAR_YELLOW  = 16'hFFE0;
    localparam logic [15:0] BAR_CYAN    = 16'h07FF;
    localparam logic [15:0] BAR_GREEN   = 16'h07E0;
    localparam logic [15:0] BAR_MAGENTA = 16'hF81F;
    localparam logic [15:0] BAR_RED     = 16'hF800;
    localparam logic [15:0] BAR_BLUE    = 16'h001F;
    localparam logic [15:0] BAR_BLACK   = 16'h0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Colour of vertical bar k, left (0) to right (7)
    function automatic logic [15:0] bar_color(input logic [2:0] k);
        logic [15:0] c;
        case (k)
            3'd0:    c = BAR_WHITE;
            3'd1:    c = BAR_YELLOW;
            3'd2:    c = BAR_CYAN;
            3'd3:    c = BAR_GREEN;
            3'd4:    c = BAR_MAGENTA;
            3'd5:    c = BAR_RED;
            3'd6:    c = BAR_BLUE;
            3'd7:    c = BAR_BLACK;
            default: c = BAR_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/wshb_if.sv
// wshb_if: 16-bit Wishbone bus between the framebuffer producers/consumers
// and the SDRAM controller.
`timescale 1ns/1ps
interface wshb_if (input logic clk);

    logic [31:0] adr;
    logic [15:0] dat_ms;
    logic [15:0] dat_sm;
    logic [1:0]  sel;
    logic        we;
    logic        stb;
    logic        cyc;
    logic        ack;
    logic [2:0]  cti;
    logic [1:0]  bte;

    modport master (
        input  clk, ack, dat_sm,
        output adr, dat_ms, sel, we, stb, cyc, cti, bte
    );

    modport slave (
        input  clk, adr, dat_ms, sel, we, stb, cyc, cti, bte,
        output ack, dat_sm
    );

endinterface

// File: rtl/mire_pixel.sv
// mire_pixel: combinational colour of one test-pattern pixel from its
// (scrolled) column and line: eight vertical bars under a 16-pixel grid.
`timescale 1ns/1ps
module mire_pixel
    import mire_pkg::*;
#(
    parameter int HDISP = 640,
    parameter int XW    = 10,
    parameter int YW    = 9
) (
    input  logic [XW-1:0] xs,
    input  logic [YW-1:0] y,
    output logic [15:0]   color
);

    localparam int BAR_W = HDISP / 8;

    logic [2:0] bar_s;

    // Bar index: number of bar left edges the column has reached
    always_comb begin
        bar_s = 3'd0;
        for (int k = 1; k < 8; k++) begin
            bar_s = bar_s + {2'b00, (xs >= XW'(k * BAR_W))};
        end
    end

    // Grid lines on every 16th column and line override the bar colour
    always_comb begin
        if ((xs[3:0] == 4'd0) || (y[3:0] == 4'd0)) begin
            color = GRID_GREY;
        end else begin
            color = bar_color(bar_s);
        end
    end

endmodule

// File: rtl/mire_writer.sv
// mire_writer: Wishbone master filling the framebuffer with the colour-bar
// test pattern, pixel (x,y) at byte address 2*(HDISP*y+x). The bus is
// released for PAUSE_LEN cycles after every BURST_LEN writes so the VGA
// reader can share the SDRAM. Optional macro MIRE_ANIM_EN: keep writing
// frames, scrolling the bars left by one pixel per frame; without it one
// frame is written and the writer parks in DONE.
`timescale 1ns/1ps
module mire_writer
    import mire_pkg::*;
#(
    parameter int HDISP     = 640,
    parameter int VDISP     = 480,
    parameter int BURST_LEN = 64,
    parameter int PAUSE_LEN = 2
) (
    input  logic   CLK,
    input  logic   NRST,
    wshb_if.master wshb_ifm,
    output logic   frame_done
);

    localparam int XW = $clog2(HDISP);
    localparam int YW = $clog2(VDISP);
    localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int PW = (PAUSE_LEN > 1) ? $clog2(PAUSE_LEN) : 1;

    localparam logic [XW-1:0] X_ZERO = XW'(32'd0);
    localparam logic [XW-1:0] X_ONE  = XW'(32'd1);
    localparam logic [XW-1:0] X_LAST = XW'(HDISP - 1);
    localparam logic [YW-1:0] Y_ZERO = YW'(32'd0);
    localparam logic [YW-1:0] Y_ONE  = YW'(32'd1);
    localparam logic [YW-1:0] Y_LAST = YW'(VDISP - 1);
    localparam logic [BW-1:0] B_ZERO = BW'(32'd0);
    localparam logic [BW-1:0] B_ONE  = BW'(32'd1);
    localparam logic [BW-1:0] B_LAST = BW'(BURST_LEN - 1);
    localparam logic [PW-1:0] P_ZERO = PW'(32'd0);
    localparam logic [PW-1:0] P_ONE  = PW'(32'd1);
    localparam logic [PW-1:0] P_LAST = PW'(PAUSE_LEN - 1);

    state_t        state_r, state_s;
    logic [XW-1:0] x_r, xs_s;
    logic [YW-1:0] y_r;
    logic [BW-1:0] burst_r;
    logic [PW-1:0] pause_r;
    logic          stb_s, hs_s;
    logic          last_x_s, last_pix_s, burst_end_s, pause_end_s;
    logic [30:0]   pix_s;
    logic [15:0]   color_s;
    logic          unused_sm;

    assign hs_s        = stb_s & wshb_ifm.ack;
    assign last_x_s    = (x_r == X_LAST);
    assign last_pix_s  = last_x_s & (y_r == Y_LAST);
    assign burst_end_s = (burst_r == B_LAST);
    assign pause_end_s = (pause_r == P_LAST);

    // State register
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next state: frame end has priority over the fair-play release
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                state_s = WRITE;
            end
            WRITE: begin
                if (hs_s && last_pix_s) begin
`ifdef MIRE_ANIM_EN
                    state_s = WRITE;
`else
                    state_s = DONE;
`endif
                end else if (hs_s && burst_end_s) begin
                    state_s = PAUSE;
                end else begin
                    state_s = WRITE;
                end
            end
            PAUSE: begin
                if (pause_end_s) begin
                    state_s = WRITE;
                end else begin
                    state_s = PAUSE;
                end
            end
            DONE: begin
                state_s = DONE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Outputs per state: the strobe is only raised while writing
    always_comb begin
        stb_s = 1'b0;
        case (state_r)
            WRITE:             stb_s = 1'b1;
            IDLE, PAUSE, DONE: stb_s = 1'b0;
            default:           stb_s = 1'b0;
        endcase
    end

    // Pixel position, advanced only by accepted writes
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            x_r <= X_ZERO;
            y_r <= Y_ZERO;
        end else if (hs_s) begin
            if (last_x_s) begin
                x_r <= X_ZERO;
                y_r <= (y_r == Y_LAST) ? Y_ZERO : y_r + Y_ONE;
            end else begin
                x_r <= x_r + X_ONE;
            end
        end
    end

    // Acks in the current burst; cleared at the burst end or frame end
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            burst_r <= B_ZERO;
        end else if (hs_s) begin
            burst_r <= (last_pix_s || burst_end_s) ? B_ZERO : burst_r + B_ONE;
        end
    end

    // Cycles spent with the bus released
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            pause_r <= P_ZERO;
        end else if (state_r == PAUSE) begin
            pause_r <= pause_end_s ? P_ZERO : pause_r + P_ONE;
        end else begin
            pause_r <= P_ZERO;
        end
    end

    // One-cycle pulse after the ack of the frame's last pixel
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            frame_done <= 1'b0;
        end else begin
            frame_done <= hs_s & last_pix_s;
        end
    end

`ifdef MIRE_ANIM_EN
    logic [XW-1:0] xs_r, offset_r, offset_next_s;

    assign offset_next_s = (offset_r == X_LAST) ? X_ZERO : offset_r + X_ONE;

    // Scrolled column: reloaded with the frame offset at each line start,
    // the offset itself stepping once per frame
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            xs_r     <= X_ZERO;
            offset_r <= X_ZERO;
        end else if (hs_s) begin
            if (last_pix_s) begin
                offset_r <= offset_next_s;
                xs_r     <= offset_next_s;
            end else if (last_x_s) begin
                xs_r <= offset_r;
            end else begin
                xs_r <= (xs_r == X_LAST) ? X_ZERO : xs_r + X_ONE;
            end
        end
    end

    assign xs_s = xs_r;
`else
    assign xs_s = x_r;
`endif

    mire_pixel #(
        .HDISP (HDISP),
        .XW    (XW),
        .YW    (YW)
    ) u_pixel (
        .xs    (xs_s),
        .y     (y_r),
        .color (color_s)
    );

    assign pix_s = (31'(HDISP) * 31'(y_r)) + 31'(x_r);

    assign wshb_ifm.adr    = {pix_s, 1'b0};
    assign wshb_ifm.dat_ms = color_s;
    assign wshb_ifm.sel    = 2'b11;
    assign wshb_ifm.we     = 1'b1;
    assign wshb_ifm.cti    = 3'b000;
    assign wshb_ifm.bte    = 2'b00;
    assign wshb_ifm.stb    = stb_s;
    assign wshb_ifm.cyc    = stb_s;

    // Read data and the interface clock are not needed by a write-only master
    assign unused_sm = ^{wshb_ifm.dat_sm, wshb_ifm.clk};

endmodule

// File: tb/tb_mire_writer.sv
// tb_mire_writer: scoreboard bench for mire_writer (640x32 frame, 64-write
// bursts, 2-cycle pauses). Expected (adr, dat) pairs are queued when a run
// is started and popped as the slave model acknowledges writes.
`timescale 1ns/1ps
module tb_mire_writer;

    localparam int H     = 640;
    localparam int V     = 32;
    localparam int BL    = 64;
    localparam int PL    = 2;
    localparam int FRAME = H * V;

    typedef struct {
        logic [31:0] adr;
        logic [15:0] dat;
        int          pix;
        int          frame;
    } exp_t;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    logic frame_done;
    logic ack_ready = 1'b0;

    int   n_checks = 0;
    int   n_errors = 0;
    int   max_delay = 0;
    int   wait_left = -1;
    int   acks = 0;
    int   hi_cyc = 0;
    int   lo_cyc = 0;
    int   fd_pulses = 0;
    bit   prev_stb = 1'b0;
    bit   after_rst = 1'b1;
    bit   fd_exp = 1'b0;
    bit   done_seen = 1'b0;
    exp_t mon_e;
    exp_t sb_q[$];

    wshb_if wb (.clk(clk));

    assign wb.ack    = wb.stb & ack_ready;
    assign wb.dat_sm = 16'h0000;

    mire_writer #(
        .HDISP     (H),
        .VDISP     (V),
        .BURST_LEN (BL),
        .PAUSE_LEN (PL)
    ) dut (
        .CLK        (clk),
        .NRST       (nrst),
        .wshb_ifm   (wb),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] model_color(input int x, input int y, input int off);
        int xs;
        xs = (x + off) % H;
        if ((xs % 16 == 0) || (y % 16 == 0)) return 16'h8410;
        case ((xs * 8) / H)
            0:       return 16'hFFFF;
            1:       return 16'hFFE0;
            2:       return 16'h07FF;
            3:       return 16'h07E0;
            4:       return 16'hF81F;
            5:       return 16'hF800;
            6:       return 16'h001F;
            default: return 16'h0000;
        endcase
    endfunction

    task automatic push_pixels(input int first, input int count, input int off, input int frame_no);
        for (int p = first; p < first + count; p++) begin
            exp_t e;
            e.pix   = p;
            e.frame = frame_no;
            e.adr   = 32'(2 * p);
            e.dat   = model_color(p % H, p / H, off);
            sb_q.push_back(e);
        end
    endtask

    task automatic spot_check(input exp_t e, input logic [31:0] adr, input logic [15:0] dat);
        if (e.frame == 1) begin
            case (e.pix)
                0:         begin check_val("px0_adr", adr, 32'd0); check_val("px0_dat", {16'd0, dat}, 32'h8410); end
                641:       begin check_val("px11_adr", adr, 32'd1282); check_val("px11_dat", {16'd0, dat}, 32'hFFFF); end
                719:       check_val("bar_x79", {16'd0, dat}, 32'hFFFF);
                720:       check_val("grid_x80", {16'd0, dat}, 32'h8410);
                721:       check_val("bar_x81", {16'd0, dat}, 32'hFFE0);
                1121:      check_val("bar_x481", {16'd0, dat}, 32'h001F);
                1201:      check_val("bar_x561", {16'd0, dat}, 32'h0000);
                FRAME - 1: check_val("last_adr", adr, 32'd40958);
                default:   ;
            endcase
        end else if ((e.frame == 2) && (e.pix == 720)) begin
            check_val("scroll_x80", {16'd0, dat}, 32'hFFE0);
        end
    endtask

    // Slave model, scoreboard and fair-play monitor, evaluated on the falling edge
    always @(negedge clk) begin
        if (!nrst) begin
            ack_ready = 1'b0;
            wait_left = -1;
            prev_stb  = 1'b0;
            after_rst = 1'b1;
            acks      = 0;
            hi_cyc    = 0;
            lo_cyc    = 0;
            fd_exp    = 1'b0;
            done_seen = 1'b0;
        end else begin
            check_val("frame_done", {31'd0, frame_done}, {31'd0, fd_exp});
            if (frame_done) fd_pulses++;
            fd_exp = 1'b0;
            check_val("cyc_eq_stb", {31'd0, wb.cyc}, {31'd0, wb.stb});
            if (wb.stb && !prev_stb) begin
                if (!after_rst) check_val("pause_len", lo_cyc, PL);
                after_rst = 1'b0;
                hi_cyc = 0;
            end
            if (!wb.stb && prev_stb && !done_seen) begin
                check_val("burst_acks", acks, BL);
                if (max_delay == 0) check_val("burst_cycles", hi_cyc, BL);
                acks   = 0;
                lo_cyc = 0;
            end
            if (wb.stb) begin
                hi_cyc++;
                if (wait_left < 0) begin
                    wait_left = (max_delay == 0) ? 0 : int'($urandom_range(max_delay, 0));
                end else if (wait_left > 0) begin
                    wait_left--;
                end
                if (sb_q.size() == 0) begin
                    ack_ready = 1'b0;
                end else begin
                    mon_e = sb_q[0];
                    check_val("adr", wb.adr, mon_e.adr);
                    check_val("dat", {16'd0, wb.dat_ms}, {16'd0, mon_e.dat});
                    ack_ready = (wait_left == 0);
                    if (ack_ready) begin
                        void'(sb_q.pop_front());
                        wait_left = -1;
                        acks++;
                        spot_check(mon_e, wb.adr, wb.dat_ms);
                        if (mon_e.pix == FRAME - 1) begin
                            fd_exp = 1'b1;
                            acks   = 0;
                            hi_cyc = 0;
`ifndef MIRE_ANIM_EN
                            done_seen = 1'b1;
`endif
                        end
                    end
                end
            end else begin
                lo_cyc++;
                ack_ready = 1'b0;
                wait_left = -1;
            end
            prev_stb = wb.stb;
        end
    end

    task automatic release_reset();
        @(negedge clk);
        #2 nrst = 1'b1;
        #1 check_val("pre_first_stb", {31'd0, wb.stb}, 32'd0);
        @(posedge clk);
        #1;
        check_val("first_stb", {31'd0, wb.stb}, 32'd1);
        check_val("first_adr", wb.adr, 32'd0);
        check_val("first_dat", {16'd0, wb.dat_ms}, 32'h8410);
    endtask

    task automatic drain(input int budget, input string tag);
        int n;
        n = 0;
        while ((sb_q.size() != 0) && (n < budget)) begin
            @(posedge clk);
            n++;
        end
        check_val(tag, sb_q.size(), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_stb"}, {31'd0, wb.stb}, 32'd0);
        check_val({tag, "_cyc"}, {31'd0, wb.cyc}, 32'd0);
        check_val({tag, "_adr"}, wb.adr, 32'd0);
        check_val({tag, "_dat"}, {16'd0, wb.dat_ms}, 32'h8410);
        check_val({tag, "_fd"}, {31'd0, frame_done}, 32'd0);
    endtask

    initial begin
        int hi;
        repeat (3) @(posedge clk);
        #1 check_reset_outputs("rst");

        // Zero-wait run over a full frame
        max_delay = 0;
        push_pixels(0, FRAME, 0, 1);
`ifdef MIRE_ANIM_EN
        push_pixels(0, 2000, 1, 2);
`endif
        release_reset();
        drain(40000, "drain_zero_wait");
        @(negedge clk);
        #1 check_val("fd_pulses", fd_pulses, 32'd1);
`ifndef MIRE_ANIM_EN
        hi = 0;
        repeat (1000) begin
            @(negedge clk);
            #1 if (wb.stb) hi++;
        end
        check_val("done_idle", hi, 32'd0);
`endif

        // Random wait states on the first part of a new frame
        @(posedge clk);
        #3 nrst = 1'b0;
        #1 check_reset_outputs("rst2");
        repeat (2) @(posedge clk);
        sb_q.delete();
        max_delay = 5;
        push_pixels(0, 3000, 0, 1);
        release_reset();
        drain(20000, "drain_random");

        // Reset while a write is stalled waiting for ack
        @(posedge clk);
        #1;
        check_val("stall_stb", {31'd0, wb.stb}, 32'd1);
        check_val("stall_adr", wb.adr, 32'd6000);
        #2 nrst = 1'b0;
        #1 check_reset_outputs("rst3");
        repeat (2) @(posedge clk);
        sb_q.delete();
        max_delay = 0;
        push_pixels(0, 700, 0, 1);
        release_reset();
        drain(5000, "drain_restart");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
